// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, captures words from a combinational
// instruction memory and hands them to decode over a valid/ready handshake.
module instruction_fetch_unit #(
    parameter int unsigned              ADDR_WIDTH = 16,
    parameter int unsigned              DATA_WIDTH = 32,
    parameter int unsigned              MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] inst_address,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  halted,
    output logic                  fetch_fault,
    output logic [15:0]           retired_count
);

    typedef enum logic [1:0] {
        FETCH,
        VALID,
        HALTED,
        FAULT
    } state_t;

    // One extra bit so a depth of 2^ADDR_WIDTH never reports a fault
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  in_range;

    assign inst_address = pc;
    assign in_range     = {1'b0, pc} < DEPTH;
    assign inst_valid   = (state == VALID);
    assign halted       = (state == HALTED);
    assign fetch_fault  = (state == FAULT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            instruction   <= '0;
            inst_pc       <= '0;
            retired_count <= '0;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= halt_req ? HALTED : FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!in_range) begin
                        state <= FAULT;
                    end else if (halt_req) begin
                        state <= HALTED;
                    end else begin
                        instruction <= read_data;
                        inst_pc     <= pc;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    if (inst_ready) begin
                        pc            <= pc + ADDR_WIDTH'(1);
                        retired_count <= retired_count + 16'd1;
                        state         <= halt_req ? HALTED : FETCH;
                    end else if (halt_req) begin
                        // Drop the word; PC is unchanged so it is refetched
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    if (!halt_req) state <= FETCH;
                end
                FAULT: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic
// compared each cycle against a flag-based behavioural model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] inst_address;
    logic [31:0] read_data;
    logic [31:0] instruction;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        fetch_fault;
    logic [15:0] retired_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: what decode would see, as plain flags and values
    int unsigned m_pc;
    int unsigned m_instr;
    int unsigned m_ipc;
    int unsigned m_count;
    bit          m_has_word;
    bit          m_stopped;
    bit          m_broken;

    always #5 clk = ~clk;

    assign read_data = 32'(inst_address);

    instruction_fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .inst_address   (inst_address),
        .read_data      (read_data),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .fetch_fault    (fetch_fault),
        .retired_count  (retired_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = 0;
        m_instr    = 0;
        m_ipc      = 0;
        m_count    = 0;
        m_has_word = 0;
        m_stopped  = 0;
        m_broken   = 0;
    endtask

    // One clock edge worth of behaviour, from the rules of the block
    task automatic model_step();
        if (redirect_valid) begin
            m_pc       = redirect_pc;
            m_has_word = 0;
            m_broken   = 0;
            m_stopped  = halt_req;
        end else if (m_broken) begin
            m_broken = 1;
        end else if (m_stopped) begin
            m_stopped = halt_req;
        end else if (m_has_word) begin
            if (inst_ready) begin
                m_pc       = (m_pc + 1) % 65536;
                m_count    = (m_count + 1) % 65536;
                m_has_word = 0;
                m_stopped  = halt_req;
            end else if (halt_req) begin
                m_has_word = 0;
                m_stopped  = 1;
            end
        end else if (m_pc >= 256) begin
            m_broken = 1;
        end else if (halt_req) begin
            m_stopped = 1;
        end else begin
            m_instr    = m_pc;
            m_ipc      = m_pc;
            m_has_word = 1;
        end
    endtask

    task automatic check_all();
        chk("address", 32'(inst_address), m_pc);
        chk("valid", 32'(inst_valid), 32'(m_has_word));
        chk("halted", 32'(halted), 32'(m_stopped));
        chk("fault", 32'(fetch_fault), 32'(m_broken));
        chk("instr", instruction, m_instr);
        chk("inst_pc", 32'(inst_pc), m_ipc);
        chk("count", 32'(retired_count), m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic go_to(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // Streaming with ready held high
        inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stream_valid", 32'(inst_valid), 1);
            chk("stream_instr", instruction, k);
            tick();
            chk("stream_gap", 32'(inst_valid), 0);
        end
        chk("stream_count", 32'(retired_count), 4);
        chk("stream_addr", 32'(inst_address), 4);

        // Backpressure at PC 7
        repeat (6) tick();
        inst_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_instr", instruction, 7);
            chk("bp_pc", 32'(inst_pc), 7);
            chk("bp_addr", 32'(inst_address), 7);
        end
        inst_ready = 1'b1;
        tick();
        chk("bp_adv", 32'(inst_address), 8);
        chk("bp_count", 32'(retired_count), 8);

        // Redirect beats a simultaneous accept
        inst_ready = 1'b0;
        go_to(16'h3);
        tick();
        chk("rd_at3", 32'(inst_pc), 3);
        inst_ready = 1'b1;
        go_to(16'h20);
        chk("rd_addr", 32'(inst_address), 32'h20);
        chk("rd_nocount", 32'(retired_count), 8);
        tick();
        chk("rd_instr", instruction, 32'h20);
        chk("rd_ipc", 32'(inst_pc), 32'h20);

        // Running off the end of memory
        go_to(16'h00ff);
        tick();
        chk("edge_instr", instruction, 32'hff);
        tick();
        chk("edge_pc", 32'(inst_address), 32'h100);
        tick();
        chk("fault_set", 32'(fetch_fault), 1);
        chk("fault_novalid", 32'(inst_valid), 0);
        tick();
        chk("fault_hold", 32'(fetch_fault), 1);
        go_to(16'h10);
        chk("fault_clr", 32'(fetch_fault), 0);
        tick();
        chk("fault_resume", instruction, 32'h10);

        // Halt in VALID, redirect while halted, resume
        inst_ready = 1'b0;
        go_to(16'h5);
        tick();
        halt_req = 1'b1;
        tick();
        chk("halt_set", 32'(halted), 1);
        chk("halt_pc", 32'(inst_address), 5);
        go_to(16'h9);
        chk("halt_keep", 32'(halted), 1);
        halt_req = 1'b0;
        tick();
        tick();
        chk("halt_resume", instruction, 9);
        chk("halt_ipc", 32'(inst_pc), 9);

        // Asynchronous reset in the middle of VALID
        go_to(16'd12);
        tick();
        chk("pre_rst", 32'(inst_pc), 12);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 32'(inst_valid), 0);
        chk("arst_instr", instruction, 0);
        chk("arst_addr", 32'(inst_address), 0);
        chk("arst_count", 32'(retired_count), 0);
        @(negedge clk);
        reset_n    = 1'b1;
        inst_ready = 1'b1;
        tick();
        chk("post_rst", instruction, 0);
        chk("post_rst_v", 32'(inst_valid), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = 16'hffff - 16'($urandom_range(0, 1));
                1: redirect_pc = 16'($urandom_range(250, 255));
                default: redirect_pc = 16'($urandom_range(0, 299));
            endcase
            if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequencer that owns the program counter and drives the instruction memory's combinational read port. Each fetch is a two-cycle multicycle step: present PC, then capture the word into the instruction register. The captured word is handed to the decode/control unit over a valid/ready handshake. The block also handles branch/jump redirects, halt/resume requests and out-of-range fetch faults, and counts instructions accepted by decode.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of PC and instruction memory address (word-addressed).
- DATA_WIDTH, 32, instruction word width.
- MEM_DEPTH, 256, number of implemented memory words; PC >= MEM_DEPTH is a fault.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- inst_address  out  ADDR_WIDTH  address to instruction memory; always equals PC (combinational).
- read_data  in  DATA_WIDTH  combinational read data from instruction memory.
- instruction  out  DATA_WIDTH  instruction register contents.
- inst_pc  out  ADDR_WIDTH  PC from which `instruction` was fetched.
- inst_valid  out  1  `instruction`/`inst_pc` valid for decode.
- inst_ready  in  1  decode accepts the instruction this cycle.
- redirect_valid  in  1  load PC from redirect_pc at the next edge.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- halt_req  in  1  level request to stop fetching.
- halted  out  1  block is in HALTED.
- fetch_fault  out  1  block is in FAULT (PC out of range).
- retired_count  out  16  count of handshakes completed (inst_valid & inst_ready), wraps at 2^16.

## Operation
States: FETCH, VALID, HALTED, FAULT. Decoded outputs: inst_valid = (state==VALID), halted = (state==HALTED), fetch_fault = (state==FAULT).

Transitions and priorities, highest first, evaluated at each edge:
- redirect_valid, any state: PC <= redirect_pc; next state is HALTED if halt_req else FETCH. A pending VALID instruction is discarded even if inst_ready=1 (no count increment).
- FETCH, PC >= MEM_DEPTH: go to FAULT. instruction and inst_pc are unchanged.
- FETCH, PC < MEM_DEPTH, halt_req=1: go to HALTED. Nothing is captured.
- FETCH, otherwise: instruction <= read_data; inst_pc <= PC; go to VALID.
- VALID, inst_ready=1: PC <= PC+1 (mod 2^ADDR_WIDTH); retired_count += 1; next state is HALTED if halt_req else FETCH.
- VALID, inst_ready=0, halt_req=1: go to HALTED. The instruction is dropped and PC is not advanced, so it is refetched on resume.
- VALID, otherwise: hold. instruction, inst_pc and PC must not change while inst_valid=1.
- HALTED, halt_req=0: go to FETCH.
- FAULT: stay. Only redirect or reset exits.

General rules:
- PC changes only on accept, redirect or reset.
- inst_address tracks PC in every state.

## Timing
- Reset (async assert, sync-safe deassert by the environment): PC=RESET_PC, state=FETCH, instruction=0, inst_pc=0, retired_count=0, inst_valid=0, halted=0, fetch_fault=0.
- First inst_valid is at the first edge after reset release, with instruction = mem[RESET_PC].
- Latency is 1 cycle from PC change to inst_valid. Throughput is 1 instruction per 2 cycles when inst_ready is held high.
- Redirect is seen at edge N. The target's word is valid after edge N+1.
- Halt is recognised at the same edge halt_req is sampled high. Resume: FETCH one cycle after halt_req is sampled low, inst_valid one cycle later.
- PC at all-ones wraps to 0 on accept. Such a PC faults first whenever MEM_DEPTH < 2^ADDR_WIDTH.

## Test plan
Bench memory model: mem[i]=i, combinational read.
- Reset, inst_ready=1 held: instruction = 0,1,2,3 with inst_valid high every other cycle. After 4 accepts, retired_count=4 and inst_address=4.
- Backpressure, inst_ready=0 for 5 cycles while in VALID at PC 7: instruction=7 and inst_pc=7 stay stable and PC stays 7. Raise inst_ready for 1 cycle: PC becomes 8 and count increments once.
- redirect_valid, redirect_pc=0x20, asserted together with inst_ready while VALID at PC 3: PC=0x20 and count not incremented. Next valid instruction=0x20 with inst_pc=0x20.
- Redirect to 0x00FF, then accept: instruction=0xFF. PC becomes 0x100, FETCH goes to FAULT, fetch_fault=1 and inst_valid stays 0. Redirect to 0x10: fault clears and next instruction=0x10.
- halt_req high in VALID at PC 5 with inst_ready=0: halted=1 and PC stays 5. Redirect to 9 while halted: still halted. Drop halt_req: next instruction=9.
- Assert reset_n=0 mid-VALID at PC 12: all outputs go to reset values immediately, without waiting for a clock edge. After release, instruction=0.
